// File: rtl/ov_frame_pkg.sv
// Shared types and helpers for the OV7670 frame writer.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package ov_frame_pkg;

   typedef enum logic [1:0] {
      S_SYNC = 2'd0,
      S_WAIT = 2'd1,
      S_CAP  = 2'd2,
      S_EVAL = 2'd3
   } state_t;

   // Expand RGB565 to RGB888 by replicating the top bits into the new LSBs.
   function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
      r = px[15:11];
      g = px[10:5];
      b = px[4:0];
      return {r, r[4:2], g, g[5:4], b, b[4:2]};
   endfunction

   // Base address of ping-pong buffer 'sel' for a w x h frame.
   function automatic int unsigned buf_base(input logic sel, input int unsigned w,
                                            input int unsigned h);
      return sel ? (w * h) : 32'd0;
   endfunction

endpackage

// File: rtl/ov_byte_packer.sv
// Pairs camera bytes into one RGB888 pixel (high byte first).
// Latency: combinational pixel out on the second byte of each pair.
// Backpressure: none; every enabled byte is consumed.
module ov_byte_packer
   import ov_frame_pkg::*;
(
   input  logic        iclk,
   input  logic        irst_n,
   input  logic        iclr,
   input  logic        ien,
   input  logic [7:0]  ibyte,
   output logic        ophase,
   output logic        opix_vld,
   output logic [23:0] opix
);

   logic       phase_q;
   logic [7:0] hi_q;

   // Toggle byte phase per accepted byte and latch the high byte on phase 0.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         phase_q <= 1'b0;
         hi_q    <= 8'd0;
      end else if (iclr) begin
         phase_q <= 1'b0;
      end else if (ien) begin
         if (!phase_q) hi_q <= ibyte;
         phase_q <= ~phase_q;
      end
   end

   assign ophase   = phase_q;
   assign opix_vld = ien & phase_q;
   assign opix     = rgb565_to_888({hi_q, ibyte});

endmodule

// File: rtl/ov_frame_writer.sv
// Captures OV7670 RGB565 frames as RGB888 into a ping-pong buffer and kicks the compressor.
// Latency: memory write one cycle after the second byte of a pixel; start two cycles after VSYNC rise.
// Backpressure: none on the camera; a busy compressor makes the good frame drop and the buffer be reused.
module ov_frame_writer
   import ov_frame_pkg::*;
#(
   parameter int pIM_WIDTH  = 640,
   parameter int pIM_HEIGHT = 480,
   parameter int pDATA_W    = 24,
   parameter int pADDR_W    = $clog2(2 * pIM_WIDTH * pIM_HEIGHT)
) (
   input  logic               iclk,
   input  logic               irst_n,
   input  logic               ivsync,
   input  logic               ihref,
   input  logic [7:0]         ibyte,
   input  logic               ibyte_valid,
   output logic [pDATA_W-1:0] odata_wr,
   output logic [pADDR_W-1:0] oaddr_wr,
   output logic               omem_wr_en,
   input  logic               icons_busy,
   output logic               ostart_work,
   output logic [pADDR_W-1:0] odata_start_ptr,
   output logic               oframe_err,
   output logic               oframe_drop
);

   localparam int PIX_W  = $clog2(pIM_WIDTH + 1);
   localparam int LINE_W = $clog2(pIM_HEIGHT + 1);
   localparam logic [PIX_W-1:0]   PIX_MAX   = PIX_W'(pIM_WIDTH);
   localparam logic [PIX_W-1:0]   PIX_ONE   = PIX_W'(1);
   localparam logic [LINE_W-1:0]  LINE_MAX  = LINE_W'(pIM_HEIGHT);
   localparam logic [LINE_W-1:0]  LINE_ONE  = LINE_W'(1);
   localparam logic [pADDR_W-1:0] ADDR_ONE  = pADDR_W'(1);
   localparam logic [pADDR_W-1:0] LINE_STEP = pADDR_W'(pIM_WIDTH);
   localparam logic [pADDR_W-1:0] BASE0     = pADDR_W'(buf_base(1'b0, pIM_WIDTH, pIM_HEIGHT));
   localparam logic [pADDR_W-1:0] BASE1     = pADDR_W'(buf_base(1'b1, pIM_WIDTH, pIM_HEIGHT));

   state_t              state_q;
   logic                vsync_q, href_q;
   logic                sel_q, err_q;
   logic [PIX_W-1:0]    pix_q;
   logic [LINE_W-1:0]   line_q;
   logic [pADDR_W-1:0]  addr_q, line_base_q;
   logic [pDATA_W-1:0]  data_wr_q;
   logic [pADDR_W-1:0]  addr_wr_q, start_ptr_q;
   logic                wr_en_q, start_q, ferr_q, fdrop_q;

   logic                vsync_rise, vsync_fall, href_fall;
   logic                pk_clr, pk_en, pk_phase, pk_vld;
   logic [23:0]         pk_pix;
   logic [pADDR_W-1:0]  base_sel;

   assign vsync_rise = ivsync & ~vsync_q;
   assign vsync_fall = ~ivsync & vsync_q;
   assign href_fall  = ~ihref & href_q;
   assign base_sel   = sel_q ? BASE1 : BASE0;

   // Phase restarts at frame start and at every line end so a stray odd byte cannot skew the next line.
   assign pk_clr = ((state_q == S_WAIT) & vsync_fall) | ((state_q == S_CAP) & href_fall);
   assign pk_en  = (state_q == S_CAP) & ihref & ibyte_valid;

   ov_byte_packer u_packer (
      .iclk     (iclk),
      .irst_n   (irst_n),
      .iclr     (pk_clr),
      .ien      (pk_en),
      .ibyte    (ibyte),
      .ophase   (pk_phase),
      .opix_vld (pk_vld),
      .opix     (pk_pix)
   );

   // Frame FSM with counters, address generation and registered outputs.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q     <= S_SYNC;
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         sel_q       <= 1'b0;
         err_q       <= 1'b0;
         pix_q       <= '0;
         line_q      <= '0;
         addr_q      <= '0;
         line_base_q <= '0;
         data_wr_q   <= '0;
         addr_wr_q   <= '0;
         start_ptr_q <= '0;
         wr_en_q     <= 1'b0;
         start_q     <= 1'b0;
         ferr_q      <= 1'b0;
         fdrop_q     <= 1'b0;
      end else begin
         vsync_q <= ivsync;
         href_q  <= ihref;
         wr_en_q <= 1'b0;
         start_q <= 1'b0;
         ferr_q  <= 1'b0;
         fdrop_q <= 1'b0;
         case (state_q)
            S_SYNC: begin
               if (ivsync) state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (vsync_fall) begin
                  pix_q       <= '0;
                  line_q      <= '0;
                  addr_q      <= base_sel;
                  line_base_q <= base_sel;
                  err_q       <= 1'b0;
                  state_q     <= S_CAP;
               end
            end
            S_CAP: begin
               if (pk_vld) begin
                  // Overrun pixels are dropped so writes stay inside the current buffer.
                  if ((pix_q == PIX_MAX) || (line_q == LINE_MAX)) begin
                     err_q <= 1'b1;
                  end else begin
                     wr_en_q   <= 1'b1;
                     data_wr_q <= pDATA_W'(pk_pix);
                     addr_wr_q <= addr_q;
                     addr_q    <= addr_q + ADDR_ONE;
                     pix_q     <= pix_q + PIX_ONE;
                  end
               end
               if (href_fall) begin
                  if ((pix_q != PIX_MAX) || pk_phase) err_q <= 1'b1;
                  if (line_q != LINE_MAX) begin
                     line_q      <= line_q + LINE_ONE;
                     line_base_q <= line_base_q + LINE_STEP;
                     addr_q      <= line_base_q + LINE_STEP;
                  end
                  pix_q <= '0;
               end
               if (vsync_rise) state_q <= S_EVAL;
            end
            S_EVAL: begin
               if (err_q || (line_q != LINE_MAX)) begin
                  ferr_q <= 1'b1;
               end else if (icons_busy) begin
                  fdrop_q <= 1'b1;
               end else begin
                  start_ptr_q <= base_sel;
                  start_q     <= 1'b1;
                  sel_q       <= ~sel_q;
               end
               state_q <= S_WAIT;
            end
            default: state_q <= S_SYNC;
         endcase
      end
   end

   assign odata_wr        = data_wr_q;
   assign oaddr_wr        = addr_wr_q;
   assign omem_wr_en      = wr_en_q;
   assign ostart_work     = start_q;
   assign odata_start_ptr = start_ptr_q;
   assign oframe_err      = ferr_q;
   assign oframe_drop     = fdrop_q;

endmodule
